mdu_ctrl: RTL

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_pkg.sv | 26 ++
 rtl/mdu_ctrl_if.sv | 28 ++
 rtl/mdu_step.sv | 30 +++
 rtl/mdu_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM
// states, the iteration count and an operand-magnitude helper.
package mdu_pkg;

    localparam int STEP_CNT = 32;
    localparam int CNT_W    = $clog2(STEP_CNT);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // Two's-complement magnitude; only negated when the operand is signed.
    function automatic logic [31:0] mag(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-stage <-> MDU connection: request, operands, MTHI/MTLO writes and the
// architectural HI/LO plus busy/done status.
interface mdu_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              flush;
    logic              hi_we;
    logic              lo_we;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, op, a, b, flush, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_step.sv
// One iteration of the unsigned datapath, MSB first: shift-add for multiply,
// restoring subtract-shift for divide. Accumulator is {hi_part, lo_part}.
module mdu_step #(
    parameter int W = 32
) (
    input  logic           i_div,
    input  logic [2*W-1:0] i_acc,
    input  logic [W-1:0]   i_opnd,
    input  logic           i_bit,
    output logic [2*W-1:0] o_acc
);
    logic [W:0]   w_rsh;
    logic [W-1:0] w_diff;
    logic         w_ge;
    logic [2*W-1:0] w_mul;

    // Remainder stays below the divisor, so the difference always fits in W bits.
    assign w_rsh  = {i_acc[2*W-1:W], i_bit};
    assign w_ge   = (w_rsh >= {1'b0, i_opnd});
    assign w_diff = w_rsh[W-1:0] - i_opnd;
    assign w_mul  = {i_acc[2*W-2:0], 1'b0} + (i_bit ? {{W{1'b0}}, i_opnd} : '0);

    always_comb begin
        o_acc = w_mul;
        if (i_div) begin
            o_acc = w_ge ? {w_diff, i_acc[W-2:0], 1'b1}
                         : {w_rsh[W-1:0], i_acc[W-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/mdu_ctrl.sv
// Iterative MIPS-style multiply/divide unit: 32 RUN steps on magnitudes, then
// a FIX cycle applies signs and commits HI/LO.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] HILO_RST = '0
) (
    input  logic      clk,
    input  logic      rst_n,
    mdu_ctrl_if.slave bus
);
    state_e              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*DATA_W-1:0] r_acc;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    op_e                 r_op;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_div0;
    logic                r_busy;
    logic                r_done;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    logic                w_div;
    logic                w_sgn_in;
    logic                w_bit;
    logic [DATA_W-1:0]   w_opnd;
    logic [2*DATA_W-1:0] w_step;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_quo;
    logic [DATA_W-1:0]   w_rem;

    assign w_div    = (r_op == OP_DIV) || (r_op == OP_DIVU);
    assign w_sgn_in = (bus.op == OP_MULT) || (bus.op == OP_DIV);

    // Multiply walks the multiplier bits; divide walks the dividend bits.
    assign w_bit  = w_div ? r_a[r_cnt] : r_b[r_cnt];
    assign w_opnd = w_div ? r_b : r_a;

    mdu_step #(.W(DATA_W)) u_step (
        .i_div  (w_div),
        .i_acc  (r_acc),
        .i_opnd (w_opnd),
        .i_bit  (w_bit),
        .o_acc  (w_step)
    );

    // A zero divisor leaves |a| in the remainder half, so restoring the dividend
    // sign reproduces a exactly; only the quotient needs forcing.
    assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    assign w_quo  = r_div0 ? '1 : (r_neg_q ? (~r_acc[DATA_W-1:0] + 1'b1) : r_acc[DATA_W-1:0]);
    assign w_rem  = r_neg_r ? (~r_acc[2*DATA_W-1:DATA_W] + 1'b1) : r_acc[2*DATA_W-1:DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= OP_MULT;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= HILO_RST;
            r_lo    <= HILO_RST;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.hi_we) r_hi <= bus.wdata;
                    if (bus.lo_we) r_lo <= bus.wdata;
                    if (bus.start && !bus.flush) begin
                        r_a     <= mag(bus.a, w_sgn_in);
                        r_b     <= mag(bus.b, w_sgn_in);
                        r_op    <= op_e'(bus.op);
                        r_neg_q <= w_sgn_in && (bus.a[DATA_W-1] ^ bus.b[DATA_W-1]);
                        r_neg_r <= w_sgn_in && bus.a[DATA_W-1];
                        r_div0  <= bus.op[1] && (bus.b == '0);
                        r_acc   <= '0;
                        r_cnt   <= CNT_W'(STEP_CNT - 1);
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.flush) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == '0) r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                    if (!bus.flush) begin
                        r_done <= 1'b1;
                        if (w_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod[2*DATA_W-1:DATA_W];
                            r_lo <= w_prod[DATA_W-1:0];
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
